// File: rtl/roi_scan_pkg.sv
// roi_scan_pkg: shared FSM states, signature width and counter sizing for the ROI scan harness.
package roi_scan_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, UNLOAD} state_t;
  localparam int SIG_W = 16;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/roi_scan_shr.sv
// roi_scan_shr: W-bit left shift register with parallel load; exposes only the top QW bits.
module roi_scan_shr #(
  parameter int W  = 8,
  parameter int QW = W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  par_in,
  input  logic          shift_en,
  input  logic          ser_in,
  output logic [QW-1:0] q
);
  logic [W-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else if (load) r <= par_in;
    else if (shift_en) r <= {r[W-2:0], ser_in};
  assign q = r[W-1 -: QW];
endmodule

// File: rtl/roi_scan_harness.sv
// roi_scan_harness: serial-in stimulus / serial-out result scan wrapper around a ROI.
// Define ROI_SIG_EN to add the 16-bit XOR-fold signature output sig.
module roi_scan_harness
  import roi_scan_pkg::*;
#(
  parameter int DIN_N      = 256,
  parameter int DOUT_N     = 256,
  parameter int SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              di,
  input  logic              di_valid,
  input  logic              stb,
  output logic [DIN_N-1:0]  roi_din,
  input  logic [DOUT_N-1:0] roi_dout,
  output logic              do_bit,
  output logic              do_valid,
  output logic              busy,
  output logic              done,
  output logic              ovr
`ifdef ROI_SIG_EN
  ,
  output logic [SIG_W-1:0]  sig
`endif
);
  localparam int BW = cnt_w(DIN_N);
  localparam int SW = cnt_w(SETTLE_CYC);
  localparam int OW = cnt_w(DOUT_N);
  state_t state, state_nx;
  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] set_cnt;
  logic [OW-1:0] out_cnt;
  logic [DIN_N-1:0] din_q, din_nx;
  logic dout_msb, in_rx, accept, apply, capture, last_out;
  assign in_rx    = state == IDLE || state == LOAD;
  assign accept   = in_rx && di_valid;
  assign apply    = in_rx && (stb || (accept && bit_cnt == BW'(DIN_N - 1)));
  assign capture  = state == SETTLE && set_cnt == SW'(SETTLE_CYC - 1);
  assign last_out = state == UNLOAD && out_cnt == OW'(DOUT_N - 1);
  // An apply sees the bit accepted on the same edge.
  assign din_nx   = accept ? {din_q[DIN_N-2:0], di} : din_q;
  roi_scan_shr #(.W(DIN_N)) u_din (
    .clk(clk), .rst_n(rst_n), .load(apply), .par_in('0),
    .shift_en(accept), .ser_in(di), .q(din_q)
  );
  roi_scan_shr #(.W(DOUT_N), .QW(1)) u_dout (
    .clk(clk), .rst_n(rst_n), .load(capture), .par_in(roi_dout),
    .shift_en(state == UNLOAD), .ser_in(1'b0), .q(dout_msb)
  );
  always_comb begin
    state_nx = state;
    state_nx = apply ? SETTLE : accept ? LOAD : capture ? UNLOAD : last_out ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      set_cnt <= '0;
      out_cnt <= '0;
      roi_din <= '0;
      done    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= apply ? '0 : accept ? bit_cnt + BW'(1) : bit_cnt;
      set_cnt <= (state == SETTLE && !capture) ? set_cnt + SW'(1) : '0;
      out_cnt <= (state == UNLOAD && !last_out) ? out_cnt + OW'(1) : '0;
      roi_din <= apply ? din_nx : roi_din;
      done    <= last_out;
      ovr     <= ovr | (di_valid & ~in_rx);
    end
  assign do_valid = state == UNLOAD;
  assign do_bit   = do_valid & dout_msb;
  assign busy     = state != IDLE;
`ifdef ROI_SIG_EN
  localparam int NCH = (DOUT_N + SIG_W - 1) / SIG_W;
  localparam int PW  = NCH * SIG_W;
  logic [PW-1:0]    pad;
  logic [SIG_W-1:0] fold;
  always_comb begin
    pad  = PW'(roi_dout);
    fold = '0;
    for (int i = 0; i < NCH; i++) fold = fold ^ pad[i*SIG_W +: SIG_W];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= '0;
    else if (capture) sig <= fold;
`endif
endmodule

// File: tb/tb_roi_scan_harness.sv
// tb_roi_scan_harness: directed scan transactions checked against a queue-based transaction model.
module tb_roi_scan_harness;
  localparam int N  = 8;
  localparam int SC = 2;
  logic clk = 0, rst_n = 0, di = 0, di_valid = 0, stb = 0, roi_mode = 0;
  logic [7:0] roi_din, roi_dout;
  logic do_bit, do_valid, busy, done, ovr;
`ifdef ROI_SIG_EN
  logic [15:0] sig;
`endif
  assign roi_dout = roi_mode ? 8'hA5 : ~roi_din;
  always #5 clk = ~clk;

  roi_scan_harness #(.DIN_N(N), .DOUT_N(N), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .di(di), .di_valid(di_valid), .stb(stb),
    .roi_din(roi_din), .roi_dout(roi_dout), .do_bit(do_bit), .do_valid(do_valid),
    .busy(busy), .done(done), .ovr(ovr)
`ifdef ROI_SIG_EN
    , .sig(sig)
`endif
  );

  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: bits accumulate until stb or N bits, then SC settle cycles,
  // then the captured ROI result is replayed MSB first from a queue.
  logic [7:0] m_acc = 0, m_din = 0, m_cap = 0;
  logic [15:0] m_sig = 0;
  logic m_done = 0, m_ovr = 0;
  int m_bits = 0, m_settle = 0;
  bit m_q[$];
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_acc = 0; m_din = 0; m_bits = 0; m_settle = 0; m_q.delete();
      m_done = 0; m_ovr = 0; m_sig = 0;
    end else begin
      m_done = 0;
      if (m_settle > 0) begin
        m_ovr = m_ovr | di_valid;
        m_settle--;
        if (m_settle == 0) begin
          m_cap = roi_mode ? 8'hA5 : ~m_din;
          for (int i = 7; i >= 0; i--) m_q.push_back(m_cap[i]);
          m_sig = {8'h00, m_cap};
        end
      end else if (m_q.size() > 0) begin
        m_ovr = m_ovr | di_valid;
        void'(m_q.pop_front());
        m_done = m_q.size() == 0;
      end else begin
        if (di_valid) begin
          m_acc = {m_acc[6:0], di};
          m_bits++;
        end
        if (stb || m_bits == N) begin
          m_din = m_acc; m_acc = 0; m_bits = 0; m_settle = SC;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_bits > 0 || m_settle > 0 || m_q.size() > 0);
    chk("do_valid", do_valid, m_q.size() > 0);
    chk("do", do_bit, m_q.size() > 0 ? m_q[0] : 1'b0);
    chk("done", done, m_done);
    chk("ovr", ovr, m_ovr);
    chk("roi_din", roi_din, m_din);
`ifdef ROI_SIG_EN
    chk("sig", sig, m_sig);
`endif
  end

  logic [7:0] stream = 0;
  int ndone = 0;
  initial forever begin
    @(negedge clk);
    if (do_valid) stream = {stream[6:0], do_bit};
    if (done) ndone++;
  end

  task automatic send(input logic [7:0] v, input int n, input bit stb_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      di = v[n-1-i]; di_valid = 1; stb = stb_last && (i == n - 1);
    end
    @(negedge clk);
    di = 0; di_valid = 0; stb = 0;
  endtask

  task automatic wait_done(input string nm);
    int c;
    for (c = 0; c < 60; c++) begin
      if (done) break;
      @(negedge clk);
    end
    chk({nm, "_in_time"}, c < 60, 1);
    #1;
  endtask

  int d0, lat, nb;
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_roi_din", roi_din, 0);
    chk("rst_do_valid", do_valid, 0);
    @(negedge clk) rst_n = 1;

    d0 = ndone;
    send(8'hB2, 8, 0);
    lat = 1;
    while (!do_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("t2_latency", lat, 3);
    wait_done("t2");
    chk("t2_roi_din", roi_din, 8'hB2);
    chk("t2_stream", stream, 8'b01001101);
    chk("t2_ndone", ndone - d0, 1);

    d0 = ndone;
    send(8'b111, 3, 0);
    @(negedge clk) stb = 1;
    @(negedge clk) stb = 0;
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    chk("t3_busy_cycles", nb, 10);
    chk("t3_done", done, 1);
    #1;
    chk("t3_roi_din", roi_din, 8'h07);
    chk("t3_stream", stream, 8'hF8);
    chk("t3_ndone", ndone - d0, 1);

    d0 = ndone;
    send(8'h3C, 8, 0);
    di = 1; di_valid = 1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) break;
    end
    di = 0; di_valid = 0;
    #1;
    chk("t4_ovr", ovr, 1);
    chk("t4_roi_din", roi_din, 8'h3C);
    chk("t4_stream", stream, 8'hC3);
    chk("t4_ndone", ndone - d0, 1);
    repeat (5) @(negedge clk);
    #1 chk("t4_ovr_sticky", ovr, 1);

    d0 = ndone;
    send(8'h5A, 8, 1);
    wait_done("t5");
    chk("t5_roi_din", roi_din, 8'h5A);
    chk("t5_stream", stream, 8'hA5);
    repeat (12) @(negedge clk);
    #1;
    chk("t5_ndone", ndone - d0, 1);
    chk("t5_idle", busy, 0);

`ifdef ROI_SIG_EN
    @(negedge clk) roi_mode = 1;
    send(8'h11, 8, 0);
    wait_done("t6");
    chk("t6_sig", sig, 16'h00A5);
    chk("t6_stream", stream, 8'hA5);
    @(negedge clk) roi_mode = 0;
`endif

    send(8'h0F, 8, 0);
    for (int c = 0; c < 20 && !do_valid; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t1_pre_do", do_bit, 1);
    #2 rst_n = 0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_do_valid", do_valid, 0);
    chk("t1_do", do_bit, 0);
    chk("t1_done", done, 0);
    chk("t1_ovr", ovr, 0);
    chk("t1_roi_din", roi_din, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    #1 chk("t1_idle_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
